prf_read_arbiter: RTL

//   Shares one physical-register-file read group (MAX_OPERANDS ports) between NUM_REQ issue queues.
//   One requester is granted per cycle, round-robin. The PRF is read combinationally in the grant cycle.

---
 rtl/prf_read_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/prf_read_arbiter.sv
// Round-robin arbiter sharing one PRF read group among NUM_REQ issue queues; grant is combinational, operand data returns registered one cycle later.
// Optional macro PRF_BYPASS_EN forwards matching writeback data over stale PRF reads in the grant cycle.
module prf_read_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_OPERANDS = 3,
  parameter int PRN_BITS     = 6,
  parameter int FU_COUNT     = 4,
  parameter int CNT_BITS     = 16
) (
  input  logic                                              i_clk,
  input  logic                                              i_rst,
  input  logic [NUM_REQ-1:0]                                i_req,
  input  logic [NUM_REQ-1:0][MAX_OPERANDS-1:0]              i_req_en,
  input  logic [NUM_REQ-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] i_req_prn,
  output logic [NUM_REQ-1:0]                                o_gnt,
  output logic [NUM_REQ-1:0]                                o_rsp_valid,
  output logic [MAX_OPERANDS-1:0][63:0]                     o_rsp_data,
  output logic [MAX_OPERANDS-1:0]                           o_prf_read_enable,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]             o_prf_read_prn,
  input  logic [MAX_OPERANDS-1:0][63:0]                     i_prf_op,
  input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]             i_set_prn_ready,
  input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] i_set_prn,
  input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][63:0]       i_set_data,
  output logic [CNT_BITS-1:0]                               o_conflict_cycles
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]                         r_rr_ptr;
  logic [NUM_REQ-1:0]                       r_rsp_valid;
  logic [MAX_OPERANDS-1:0][63:0]            r_rsp_data;
  logic [CNT_BITS-1:0]                      r_conflict;

  logic                                     w_any;
  logic [PTR_W-1:0]                         w_win;
  logic [NUM_REQ-1:0]                       w_gnt;
  logic [MAX_OPERANDS-1:0]                  w_rd_en;
  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]    w_rd_prn;
  logic [MAX_OPERANDS-1:0][63:0]            w_opnd;
  logic                                     w_multi;

  // Scan from the pointer; reset suppresses any grant.
  always_comb begin
    int idx;
    w_any = 1'b0;
    w_win = '0;
    w_gnt = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_any && i_req[idx]) begin
        w_any = 1'b1;
        w_win = PTR_W'(idx);
      end
    end
    if (i_rst) w_any = 1'b0;
    if (w_any) w_gnt[w_win] = 1'b1;
  end

  always_comb begin
    w_rd_en  = '0;
    w_rd_prn = '0;
    for (int j = 0; j < MAX_OPERANDS; j++) begin
      if (w_any && i_req_en[w_win][j]) begin
        w_rd_en[j]  = 1'b1;
        w_rd_prn[j] = i_req_prn[w_win][j];
      end
    end
  end

`ifdef PRF_BYPASS_EN
  // Writeback in the read cycle is newer than the PRF array; lowest FU, then lowest slot, wins.
  always_comb begin
    logic hit;
    w_opnd = i_prf_op;
    for (int j = 0; j < MAX_OPERANDS; j++) begin
      hit = 1'b0;
      for (int k = 0; k < FU_COUNT; k++) begin
        for (int m = 0; m < MAX_OPERANDS; m++) begin
          if (!hit && i_set_prn_ready[k][m] && (i_set_prn[k][m] == w_rd_prn[j])) begin
            hit       = 1'b1;
            w_opnd[j] = i_set_data[k][m];
          end
        end
      end
    end
  end
`else
  wire w_unused_set = ^{i_set_prn_ready, i_set_prn, i_set_data};
  always_comb w_opnd = i_prf_op;
`endif

  assign w_multi = ($countones(i_req) >= 2);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr    <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_conflict  <= '0;
    end else begin
      r_rsp_valid <= w_gnt;
      if (w_any) begin
        r_rr_ptr <= (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + PTR_W'(1);
        for (int j = 0; j < MAX_OPERANDS; j++)
          r_rsp_data[j] <= w_rd_en[j] ? w_opnd[j] : 64'h0;
      end
      if (w_multi && (r_conflict != {CNT_BITS{1'b1}}))
        r_conflict <= r_conflict + CNT_BITS'(1);
    end
  end

  // A response registered just before reset is dropped while reset is held.
  assign o_gnt             = w_gnt;
  assign o_rsp_valid       = i_rst ? '0 : r_rsp_valid;
  assign o_rsp_data        = i_rst ? '0 : r_rsp_data;
  assign o_prf_read_enable = w_rd_en;
  assign o_prf_read_prn    = w_rd_prn;
  assign o_conflict_cycles = r_conflict;

endmodule
